instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-side producer for the 8-bit processor: fetches 8-bit instruction words from instruction memory and holds each one in an instruction register (IR).
- Splits the IR into opcode/rs/rd/shamt fields and presents them to the decode stage over a valid/ready handshake.
- Owns the 8-bit program counter, PC redirect (jump/branch) and fetch-timeout detection.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
MAX_WAIT, 15, max cycles imem_req may stay high without imem_ack before abort (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  level; 1 = keep fetching, 0 = stop after current handshake
imem_req  out  1  instruction memory request, held until ack
imem_addr  out  8  fetch address, stable while imem_req=1
imem_ack  in  1  memory accepted request; imem_rdata valid same cycle
imem_rdata  in  8  instruction word
instr_valid  out  1  IR holds an undelivered instruction
instr_ready  in  1  decode stage accepts the instruction
opcode  out  3  IR[7:5]
rs  out  1  IR[4]
rd  out  1  IR[3]
shamt  out  3  IR[2:0]
instr_pc  out  8  address the held instruction was fetched from
redirect_valid  in  1  one-cycle pulse: load new PC
redirect_pc  in  8  redirect target
fetch_err  out  1  one-cycle pulse on fetch timeout
busy  out  1  1 whenever state != IDLE

Behaviour:
- All state and outputs are registered. Field outputs are wires from IR.
- Reset (rst_n=0 at a clk edge): state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, IR=0, instr_pc=0, instr_valid=0, imem_req=0, fetch_err=0, busy=0, wait_cnt=0. Reset overrides every other input, including during an outstanding request. The request is dropped, not completed.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - imem_req=0, instr_valid=0.
  - run=1 -> FETCH, with imem_addr=pc and wait_cnt=0.
- FETCH:
  - imem_req=1; imem_addr is held.
  - imem_ack=1 -> IR<=imem_rdata, instr_pc<=pc, pc<=pc+1 (mod 256, 8'hFF wraps to 8'h00), instr_valid<=1, go to HOLD. imem_req is 0 the next cycle.
  - No ack -> wait_cnt increments.
  - Timeout: wait_cnt==MAX_WAIT-1 with no ack -> fetch_err=1 for one cycle, go to IDLE, pc unchanged, IR unchanged.
- HOLD:
  - instr_valid=1; IR and all field outputs stay stable until the handshake.
  - instr_valid & instr_ready -> instr_valid<=0. Then run=1 -> FETCH (imem_addr<=pc); run=0 -> IDLE.
- Latency: from entering FETCH with ack in the first cycle, instr_valid rises 1 cycle later. Sustained throughput is 1 instruction per 2 cycles (ack immediate, ready always high).
- Redirect:
  - Has priority over ack, handshake and timeout in any state.
  - pc<=redirect_pc, imem_addr<=redirect_pc, instr_valid<=0, wait_cnt<=0, state<=FETCH. An ack in the same cycle is discarded.
  - In IDLE, redirect only updates pc and stays in IDLE.
- run falling while in FETCH does not abort; the fetch completes and the instruction is delivered.
- The ack+redirect same-cycle case is the only way an accepted memory word is lost; the consumer must tolerate it.

Optional Feature:
IFU_PREFETCH_EN
- Defined: adds a 1-entry prefetch buffer (PB) plus a PB valid flag.
  - In HOLD with run=1 and PB empty, imem_req is asserted for pc.
  - On ack, the word goes into PB with its address and pc increments.
  - On handshake with PB full: IR<=PB, instr_valid stays 1, and the next prefetch starts the same cycle.
  - Result: sustained throughput of 1 instruction/cycle with same-cycle acks.
  - Redirect flushes PB.
  - Timeout during a prefetch -> fetch_err pulses and PB stays empty. IR is unaffected and is still delivered, then the block goes to IDLE.
- Undefined: no PB; behaviour exactly as in Behaviour. Reset clears PB.

Test Plan:
- Reset with RESET_PC=8'h10, run=1, memory acks immediately with 8'hA5 at 8'h10 -> imem_addr=8'h10; instr_valid=1 with opcode=3'b101, rs=0, rd=0, shamt=3'b101, instr_pc=8'h10; next imem_addr=8'h11.
- instr_ready=0 for 5 cycles in HOLD -> fields and instr_valid stable; no imem_req (without IFU_PREFETCH_EN); fetch resumes the cycle after ready=1.
- Memory never acks, MAX_WAIT=15 -> imem_req high for exactly 15 cycles, fetch_err single pulse, state IDLE, pc unchanged.
- PC at 8'hFF, fetch completes -> pc=8'h00, next imem_addr=8'h00.
- redirect_valid with redirect_pc=8'h40 in the same cycle as imem_ack -> word discarded, instr_valid=0, next request at 8'h40.
- rst_n=0 mid-FETCH -> next cycle imem_req=0, instr_valid=0, pc=RESET_PC. With IFU_PREFETCH_EN, ready=1 and immediate acks -> instr_valid stays high and instr_pc increments every cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage for the 8-bit processor.
// Fetches 8-bit words from instruction memory into the IR, presents the
// decoded fields over a valid/ready handshake and owns the PC, redirects
// and fetch-timeout detection.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   run                   keep fetching while high
//   imem_req/addr         memory request (held until ack) and address
//   imem_ack/rdata        memory accept strobe and same-cycle data
//   instr_valid/ready     IR-to-decode handshake
//   opcode/rs/rd/shamt    IR fields (combinational slices of the IR)
//   instr_pc              address the held instruction came from
//   redirect_valid/pc     one-cycle PC redirect request
//   fetch_err             one-cycle pulse on fetch timeout
//   busy                  high whenever the FSM is not idle
//
// Optional build macro IFU_PREFETCH_EN adds a one-entry prefetch buffer
// so a new fetch can overlap the instruction held in HOLD.
module instr_fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [2:0] opcode,
  output logic       rs,
  output logic       rd,
  output logic [2:0] shamt,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       fetch_err,
  output logic       busy
);

  localparam int unsigned AW  = 8;
  localparam int unsigned IW  = 8;
  localparam int unsigned WCW = 8;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d, addr_d, ipc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [WCW-1:0] wait_cnt, wcnt_d;
  logic           req_d, valid_d, err_d;
  logic           hs, tmo;
`ifdef IFU_PREFETCH_EN
  logic [IW-1:0]  pb_q, pb_d;
  logic [AW-1:0]  pb_pc_q, pb_pc_d;
  logic           pb_valid_q, pb_valid_d;
  logic           pf_stop_q, pf_stop_d;   // a prefetch timed out: no refetch until IR drains
`endif

  assign opcode = ir_q[7:5];
  assign rs     = ir_q[4];
  assign rd     = ir_q[3];
  assign shamt  = ir_q[2:0];

  assign hs  = instr_valid & instr_ready;
  assign tmo = (wait_cnt == WCW'(MAX_WAIT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = imem_addr;
    req_d   = imem_req;
    ir_d    = ir_q;
    ipc_d   = instr_pc;
    valid_d = instr_valid;
    err_d   = 1'b0;
    wcnt_d  = wait_cnt;
`ifdef IFU_PREFETCH_EN
    pb_d       = pb_q;
    pb_pc_d    = pb_pc_q;
    pb_valid_d = pb_valid_q;
    pf_stop_d  = pf_stop_q;
`endif
    if (redirect_valid) begin
      // Redirect wins over ack/handshake/timeout; a same-cycle ack is dropped
      pc_d = redirect_pc;
`ifdef IFU_PREFETCH_EN
      pb_valid_d = 1'b0;
      pf_stop_d  = 1'b0;
`endif
      if (state_q != IDLE) begin
        addr_d  = redirect_pc;
        req_d   = 1'b1;
        valid_d = 1'b0;
        wcnt_d  = '0;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
            wcnt_d  = '0;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + AW'(1);
            valid_d = 1'b1;
            state_d = HOLD;
`ifdef IFU_PREFETCH_EN
            req_d  = run;
            addr_d = pc_q + AW'(1);
            wcnt_d = '0;
`else
            req_d  = 1'b0;
`endif
          end else if (tmo) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            wcnt_d = wait_cnt + WCW'(1);
          end
        end
        HOLD: begin
`ifdef IFU_PREFETCH_EN
          if (imem_req) begin
            if (imem_ack) begin
              pc_d = pc_q + AW'(1);
              if (hs) begin
                // Delivered and refilled in the same cycle: bypass the PB
                ir_d   = imem_rdata;
                ipc_d  = pc_q;
                addr_d = pc_q + AW'(1);
                wcnt_d = '0;
                req_d  = run;
              end else begin
                pb_d       = imem_rdata;
                pb_pc_d    = pc_q;
                pb_valid_d = 1'b1;
                req_d      = 1'b0;
              end
            end else if (tmo) begin
              err_d     = 1'b1;
              req_d     = 1'b0;
              pf_stop_d = 1'b1;
              if (hs) begin
                valid_d   = 1'b0;
                pf_stop_d = 1'b0;
                state_d   = IDLE;
              end
            end else begin
              wcnt_d = wait_cnt + WCW'(1);
              if (hs) begin
                valid_d = 1'b0;
                state_d = FETCH;
              end
            end
          end else if (hs) begin
            if (pb_valid_q) begin
              ir_d       = pb_q;
              ipc_d      = pb_pc_q;
              pb_valid_d = 1'b0;
              if (run) begin
                req_d  = 1'b1;
                addr_d = pc_q;
                wcnt_d = '0;
              end
            end else begin
              valid_d   = 1'b0;
              pf_stop_d = 1'b0;
              if (run && !pf_stop_q) begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
                wcnt_d  = '0;
              end else begin
                state_d = IDLE;
              end
            end
          end else if (run && !pb_valid_q && !pf_stop_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            wcnt_d = '0;
          end
`else
          if (hs) begin
            valid_d = 1'b0;
            if (run) begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = pc_q;
              wcnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      ir_q        <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      busy        <= 1'b0;
      wait_cnt    <= '0;
`ifdef IFU_PREFETCH_EN
      pb_q        <= '0;
      pb_pc_q     <= '0;
      pb_valid_q  <= 1'b0;
      pf_stop_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr   <= addr_d;
      imem_req    <= req_d;
      ir_q        <= ir_d;
      instr_pc    <= ipc_d;
      instr_valid <= valid_d;
      fetch_err   <= err_d;
      busy        <= (state_d != IDLE);
      wait_cnt    <= wcnt_d;
`ifdef IFU_PREFETCH_EN
      pb_q        <= pb_d;
      pb_pc_q     <= pb_pc_d;
      pb_valid_q  <= pb_valid_d;
      pf_stop_q   <= pf_stop_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (default build, no prefetch).
// Directed scenarios followed by a long randomized run, all compared
// against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam logic [7:0]  RST_PC = 8'h10;
  localparam int unsigned MAXW   = 15;

  logic       clk = 1'b0;
  logic       rst_n, run, imem_req, imem_ack, instr_valid, instr_ready;
  logic       rs, rd, redirect_valid, fetch_err, busy;
  logic [7:0] imem_addr, imem_rdata, instr_pc, redirect_pc;
  logic [2:0] opcode, shamt;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rs(rs), .rd(rd), .shamt(shamt), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int ack_pct;
  logic [7:0] mem [256];

  // Reference model: a request is either outstanding, an instruction is
  // held for decode, or neither (idle).
  logic [7:0] m_pc, m_addr, m_ir, m_ipc;
  logic       m_req, m_have, m_err;
  int         m_waited;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_req();
    m_req    = 1'b1;
    m_addr   = m_pc;
    m_waited = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = RST_PC; m_addr = RST_PC; m_ir = 8'h00; m_ipc = 8'h00;
      m_req = 1'b0; m_have = 1'b0; m_err = 1'b0; m_waited = 0;
    end else begin
      m_err = 1'b0;
      if (redirect_valid) begin
        m_pc = redirect_pc;
        if (m_req || m_have) begin
          m_have = 1'b0;
          start_req();
        end
      end else if (m_req) begin
        if (imem_ack) begin
          m_ir   = imem_rdata;
          m_ipc  = m_pc;
          m_pc   = m_pc + 8'd1;
          m_have = 1'b1;
          m_req  = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == int'(MAXW)) begin
            m_err = 1'b1;
            m_req = 1'b0;
          end
        end
      end else if (m_have) begin
        if (instr_ready) begin
          m_have = 1'b0;
          if (run) start_req();
        end
      end else if (run) begin
        start_req();
      end
    end
  endtask

  // One clock: memory answers the current request, then outputs are compared
  task automatic step();
    imem_ack   = (imem_req === 1'b1) && (int'($urandom_range(99)) < ack_pct);
    imem_rdata = mem[imem_addr];
    @(posedge clk);
    model_edge();
    #1;
    check("imem_req",    32'(imem_req),    32'(m_req));
    check("imem_addr",   32'(imem_addr),   32'(m_addr));
    check("instr_valid", 32'(instr_valid), 32'(m_have));
    check("ir_fields",   32'({opcode, rs, rd, shamt}), 32'(m_ir));
    check("instr_pc",    32'(instr_pc),    32'(m_ipc));
    check("fetch_err",   32'(fetch_err),   32'(m_err));
    check("busy",        32'(busy),        32'(m_req || m_have));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int sel;
    logic [7:0] a0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;

    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    imem_ack = 1'b0; imem_rdata = 8'h00; ack_pct = 100;
    step(); step();
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_addr",  32'(imem_addr),   32'h10);
    check("rst_ipc",   32'(instr_pc),    32'h0);

    // First fetch from RESET_PC with an immediate ack
    rst_n = 1'b1; run = 1'b1;
    step();
    check("first_req",  32'(imem_req),  32'd1);
    check("first_addr", 32'(imem_addr), 32'h10);
    step();
    check("first_valid",  32'(instr_valid), 32'd1);
    check("first_opcode", 32'(opcode),      32'd5);
    check("first_rs",     32'(rs),          32'd0);
    check("first_rd",     32'(rd),          32'd0);
    check("first_shamt",  32'(shamt),       32'd5);
    check("first_ipc",    32'(instr_pc),    32'h10);

    // Decode stalls for 5 cycles: nothing moves, no new request
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req",   32'(imem_req),    32'd0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_ir",    32'({opcode, rs, rd, shamt}), 32'hA5);
    end
    instr_ready = 1'b1;
    step();
    check("resume_req",  32'(imem_req),  32'd1);
    check("resume_addr", 32'(imem_addr), 32'h11);

    // Memory never answers: request lasts exactly MAX_WAIT cycles
    ack_pct = 0;
    a0 = imem_addr;
    cnt = 0;
    while (imem_req && cnt < 100) begin
      cnt++;
      step();
    end
    check("tmo_req_cycles", 32'(cnt),       32'(MAXW));
    check("tmo_err",        32'(fetch_err), 32'd1);
    check("tmo_busy",       32'(busy),      32'd0);
    step();
    check("tmo_err_pulse",  32'(fetch_err), 32'd0);
    check("tmo_refetch",    32'(imem_req),  32'd1);
    check("tmo_pc_kept",    32'(imem_addr), 32'(a0));

    // PC wrap from 8'hFF
    ack_pct = 100;
    redirect_valid = 1'b1; redirect_pc = 8'hFF; instr_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'hFF);
    step();
    check("wrap_ipc", 32'(instr_pc), 32'hFF);
    instr_ready = 1'b1;
    step();
    check("wrap_next_addr", 32'(imem_addr), 32'h00);
    check("wrap_next_req",  32'(imem_req),  32'd1);

    // Redirect in the same cycle as an ack: the word is dropped
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_ack_seen", 32'(imem_ack),    32'd1);
    check("redir_valid",    32'(instr_valid), 32'd0);
    check("redir_addr",     32'(imem_addr),   32'h40);
    check("redir_req",      32'(imem_req),    32'd1);
    step();
    check("redir_ipc", 32'(instr_pc), 32'h40);

    // Reset while a request is outstanding
    step();
    ack_pct = 0;
    step();
    check("midrst_pre_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_req",   32'(imem_req),    32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_addr",  32'(imem_addr),   32'h10);
    rst_n = 1'b1;
    step();
    check("midrst_restart", 32'(imem_addr), 32'h10);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        sel = int'($urandom_range(3));
        ack_pct = (sel == 0) ? 100 : (sel == 1) ? 60 : (sel == 2) ? 20 : 0;
      end
      run            = ($urandom_range(9) < 8);
      instr_ready    = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = 8'($urandom);
      rst_n          = ($urandom_range(399) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
